// File: rtl/song_player.sv
// song_player: walks the notes of the selected song in a constant melody ROM and
// drives the buzzer tone generator with a half-period divider (0 = silence).
// Build option: define SONG_LOOP_EN to repeat the song forever instead of stopping
// with a one-cycle song_done pulse.
module song_player #(
    parameter int CLK_FREQ   = 100_000_000,
    parameter int BEAT_DIV   = 25_000_000,
    parameter int GAP_CYCLES = 2_500_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        play_en,
    input  logic [2:0]  song_sel,
    output logic [21:0] note_div,
    output logic [3:0]  note_idx,
    output logic        playing,
    output logic        song_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_PLAY = 2'd2;

    // Half-period in clk cycles for a tone of f Hz, folded to a constant at elaboration.
    function automatic logic [21:0] calc_div(input int f);
        return 22'(CLK_FREQ / (2 * f));
    endfunction

    // Indexed by pitch code; rest (0) and END (15) give silence.
    localparam logic [21:0] DIV_TAB [16] = '{
        22'd0,
        calc_div(262), calc_div(294), calc_div(330), calc_div(349),
        calc_div(392), calc_div(440), calc_div(494),
        calc_div(523), calc_div(587), calc_div(659), calc_div(698),
        calc_div(784), calc_div(880), calc_div(988),
        22'd0
    };

    // Melody ROM, entry = {len[1:0], pitch[3:0]}; pitch 4'hF marks END.
    localparam logic [5:0] SONG0 [16] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                                          6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
    localparam logic [5:0] SONG1 [16] = '{6'h15, 6'h00, 6'h05, 6'h28, 6'h03, 6'h0F, 6'h0F, 6'h0F,
                                          6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
    localparam logic [5:0] SONG2 [16] = '{6'h03, 6'h03, 6'h1A, 6'h00, 6'h3C, 6'h0F, 6'h0F, 6'h0F,
                                          6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
    localparam logic [5:0] SONG3 [16] = '{6'h2E, 6'h0D, 6'h1C, 6'h0B, 6'h0F, 6'h0F, 6'h0F, 6'h0F,
                                          6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
    localparam logic [5:0] SONG4 [16] = '{6'h01, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F,
                                          6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
    // Song 5 fills all 16 slots, so it ends through the index wrap rather than an END entry.
    localparam logic [5:0] SONG5 [16] = '{6'h01, 6'h03, 6'h05, 6'h18, 6'h0A, 6'h0C, 6'h0E, 6'h00,
                                          6'h0D, 6'h0B, 6'h09, 6'h07, 6'h06, 6'h04, 6'h02, 6'h11};

    logic [1:0]  state_reg;
    logic [3:0]  idx_reg;
    logic [31:0] dur_cnt_reg;
    logic [21:0] div_reg;
    logic [2:0]  sel_reg;
    logic        wrap_reg;      // LOAD entered through the 15->0 wrap: treat as END
    logic        wait_rel_reg;  // song finished; play_en must drop before a new start
    logic [5:0]  rom_data;
    logic        end_hit;
    logic        sel_valid;
    logic        sel_changed;

    // ROM read for the current song/note.
    always_comb begin
        rom_data = 6'h0F;
        case (sel_reg)
            3'd0: rom_data = SONG0[idx_reg];
            3'd1: rom_data = SONG1[idx_reg];
            3'd2: rom_data = SONG2[idx_reg];
            3'd3: rom_data = SONG3[idx_reg];
            3'd4: rom_data = SONG4[idx_reg];
            3'd5: rom_data = SONG5[idx_reg];
            default: rom_data = 6'h0F;
        endcase
    end

    assign end_hit     = (rom_data[3:0] == 4'hF) || wrap_reg;
    assign sel_valid   = (song_sel < 3'd6);
    assign sel_changed = (song_sel != sel_reg);

    // Sequencer: IDLE -> LOAD -> PLAY -> LOAD ...; stop beats restart beats normal flow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= S_IDLE;
            idx_reg      <= 4'd0;
            dur_cnt_reg  <= 32'd0;
            div_reg      <= 22'd0;
            sel_reg      <= 3'd0;
            wrap_reg     <= 1'b0;
            wait_rel_reg <= 1'b0;
        end else begin
            sel_reg <= song_sel;
            if (state_reg == S_IDLE) begin
                idx_reg  <= 4'd0;
                wrap_reg <= 1'b0;
                if (!play_en)
                    wait_rel_reg <= 1'b0;
                if (play_en && sel_valid && !wait_rel_reg)
                    state_reg <= S_LOAD;
            end else if (!play_en || !sel_valid) begin
                state_reg <= S_IDLE;
                idx_reg   <= 4'd0;
                wrap_reg  <= 1'b0;
            end else if (sel_changed) begin
                state_reg <= S_LOAD;
                idx_reg   <= 4'd0;
                wrap_reg  <= 1'b0;
            end else if (state_reg == S_LOAD) begin
                if (end_hit) begin
                    idx_reg  <= 4'd0;
                    wrap_reg <= 1'b0;
`ifdef SONG_LOOP_EN
                    state_reg <= S_LOAD;
`else
                    state_reg    <= S_IDLE;
                    wait_rel_reg <= 1'b1;
`endif
                end else begin
                    div_reg     <= DIV_TAB[rom_data[3:0]];
                    dur_cnt_reg <= 32'((int'(rom_data[5:4]) + 1) * BEAT_DIV - 1);
                    state_reg   <= S_PLAY;
                end
            end else begin
                if (dur_cnt_reg == 32'd0) begin
                    state_reg <= S_LOAD;
                    idx_reg   <= idx_reg + 4'd1;
                    wrap_reg  <= (idx_reg == 4'd15);
                end else begin
                    dur_cnt_reg <= dur_cnt_reg - 32'd1;
                end
            end
        end
    end

    // Tone is gated off during the tail of each note to articulate repeated pitches.
    always_comb begin
        note_div = 22'd0;
        if (state_reg == S_PLAY && dur_cnt_reg >= 32'(GAP_CYCLES))
            note_div = div_reg;
    end

    assign note_idx = idx_reg;
    assign playing  = (state_reg != S_IDLE);

`ifdef SONG_LOOP_EN
    assign song_done = 1'b0;
`else
    assign song_done = (state_reg == S_LOAD) && end_hit && play_en && sel_valid && !sel_changed;
`endif

endmodule

// File: tb/tb_song_player.sv
// Testbench for song_player with small timing constants. The reference model expands
// a song table into the expected per-cycle output trace from the note rules.
module tb_song_player;

    localparam int CLK_FREQ   = 1_000_000;
    localparam int BEAT_DIV   = 4;
    localparam int GAP_CYCLES = 1;
`ifdef SONG_LOOP_EN
    localparam bit LOOP = 1'b1;
`else
    localparam bit LOOP = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        play_en;
    logic [2:0]  song_sel;
    logic [21:0] note_div;
    logic [3:0]  note_idx;
    logic        playing;
    logic        song_done;

    song_player #(
        .CLK_FREQ(CLK_FREQ),
        .BEAT_DIV(BEAT_DIV),
        .GAP_CYCLES(GAP_CYCLES)
    ) dut (
        .clk(clk),
        .rst(rst),
        .play_en(play_en),
        .song_sel(song_sel),
        .note_div(note_div),
        .note_idx(note_idx),
        .playing(playing),
        .song_done(song_done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [21:0] div;
        logic [3:0]  idx;
        logic        play;
        logic        done;
    } obs_t;

    localparam obs_t IDLE_OBS = '{div: 22'd0, idx: 4'd0, play: 1'b0, done: 1'b0};

    int          freq_tab [16] = '{0, 262, 294, 330, 349, 392, 440, 494,
                                   523, 587, 659, 698, 784, 880, 988, 0};
    logic [5:0]  song_tab [0:5][0:15];
    obs_t        exp_q[$];
    int          nerr = 0;
    int          nchecks = 0;

    function automatic logic [21:0] tone_div(input int pitch);
        if (pitch == 0 || pitch == 15)
            return 22'd0;
        return 22'(CLK_FREQ / (2 * freq_tab[pitch]));
    endfunction

    // Expected trace from the cycle after the start edge: per note one silent LOAD
    // cycle, tone for all but the last GAP_CYCLES of the note, then the END LOAD.
    task automatic build(input int s);
        int reps;
        exp_q.delete();
        reps = LOOP ? 3 : 1;
        for (int r = 0; r < reps; r++) begin
            for (int n = 0; n <= 16; n++) begin
                logic [5:0] e;
                int cycles;
                logic [21:0] d;
                if (n == 16) begin
                    exp_q.push_back('{div: 22'd0, idx: 4'd0, play: 1'b1, done: !LOOP});
                    break;
                end
                e = song_tab[s][n];
                if (e[3:0] == 4'hF) begin
                    exp_q.push_back('{div: 22'd0, idx: 4'(n), play: 1'b1, done: !LOOP});
                    break;
                end
                exp_q.push_back('{div: 22'd0, idx: 4'(n), play: 1'b1, done: 1'b0});
                cycles = (int'(e[5:4]) + 1) * BEAT_DIV;
                d = tone_div(int'(e[3:0]));
                for (int c = 0; c < cycles; c++)
                    exp_q.push_back('{div: (c < cycles - GAP_CYCLES) ? d : 22'd0,
                                      idx: 4'(n), play: 1'b1, done: 1'b0});
            end
        end
    endtask

    function automatic obs_t exp_at(input int j);
        if (j < exp_q.size())
            return exp_q[j];
        return IDLE_OBS;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchecks++;
        assert (got === want) else begin
            nerr++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, got, want);
        end
    endtask

    task automatic chk_obs(input string tag, input obs_t e);
        chk({tag, ".note_div"}, 32'(note_div), 32'(e.div));
        chk({tag, ".note_idx"}, 32'(note_idx), 32'(e.idx));
        chk({tag, ".playing"}, 32'(playing), 32'(e.play));
        chk({tag, ".song_done"}, 32'(song_done), 32'(e.done));
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Start song s, follow the model for d cycles, then disturb it:
    // kind 0 = drop play_en, 1 = invalid selection, 2 = switch song, 3 = reset.
    task automatic run_trial(input int s, input int kind, input int d);
        int s2;
        int errs0;
        errs0 = nerr;
        build(s);
        song_sel = 3'(s);
        play_en  = 1'b1;
        for (int j = 0; j < d; j++) begin
            step();
            chk_obs($sformatf("song%0d.c%0d", s, j), exp_at(j));
        end
        case (kind)
            0: begin
                play_en = 1'b0;
                step();
                chk_obs("stop", IDLE_OBS);
            end
            1: begin
                song_sel = 3'($urandom_range(6, 7));
                step();
                chk_obs("invalid", IDLE_OBS);
            end
            2: begin
                s2 = (s + int'($urandom_range(1, 5))) % 6;
                song_sel = 3'(s2);
                build(s2);
                for (int j = 0; j < 40 && j < exp_q.size(); j++) begin
                    step();
                    chk_obs($sformatf("switch%0d.c%0d", s2, j), exp_at(j));
                end
            end
            default: begin
                #2 rst = 1'b1;
                #1;
                chk_obs("async_rst", IDLE_OBS);
                play_en = 1'b0;
                @(negedge clk);
                rst = 1'b0;
            end
        endcase
        $display("trial song=%0d kind=%0d at=%0d errors=%0d", s, kind, d, nerr - errs0);
        play_en  = 1'b0;
        song_sel = 3'd0;
        step();
        step();
    endtask

    initial begin
        song_tab[0] = '{6'h01, 6'h02, 6'h03, 6'h04, 6'h05, 6'h06, 6'h07, 6'h08,
                        6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
        song_tab[1] = '{6'h15, 6'h00, 6'h05, 6'h28, 6'h03, 6'h0F, 6'h0F, 6'h0F,
                        6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
        song_tab[2] = '{6'h03, 6'h03, 6'h1A, 6'h00, 6'h3C, 6'h0F, 6'h0F, 6'h0F,
                        6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
        song_tab[3] = '{6'h2E, 6'h0D, 6'h1C, 6'h0B, 6'h0F, 6'h0F, 6'h0F, 6'h0F,
                        6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
        song_tab[4] = '{6'h01, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F,
                        6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F, 6'h0F};
        song_tab[5] = '{6'h01, 6'h03, 6'h05, 6'h18, 6'h0A, 6'h0C, 6'h0E, 6'h00,
                        6'h0D, 6'h0B, 6'h09, 6'h07, 6'h06, 6'h04, 6'h02, 6'h11};

        rst      = 1'b1;
        play_en  = 1'b0;
        song_sel = 3'd0;
        repeat (3) step();
        chk_obs("reset", IDLE_OBS);
        rst = 1'b0;
        step();
        chk_obs("idle", IDLE_OBS);

        // Song 0 end to end; play_en stays high afterwards and must not restart it.
        build(0);
        play_en = 1'b1;
        for (int j = 0; j < exp_q.size() + (LOOP ? 0 : 10); j++) begin
            step();
            chk_obs($sformatf("song0.c%0d", j), exp_at(j));
            if (j == 1) chk("c4_first_tone", 32'(note_div), 32'd1908);
            if (j == 4) chk("c4_gap", 32'(note_div), 32'd0);
            if (j == 6) chk("d4_first_tone", 32'(note_div), 32'd1700);
        end
        $display("song0 full run errors=%0d", nerr);
        play_en = 1'b0;
        step();
        step();

        // Directed disturbances, including a switch during the third note of song 0.
        run_trial(0, 2, 13);
        run_trial(0, 0, 7);
        run_trial(0, 1, 8);
        run_trial(1, 3, 6);
        run_trial(5, 0, 60);

        // Random songs, disturbance kinds and disturbance points.
        for (int t = 0; t < 25; t++) begin
            int s;
            int kind;
            int span;
            s = int'($urandom_range(0, 5));
            kind = int'($urandom_range(0, 3));
            build(s);
            span = exp_q.size();
            run_trial(s, kind, int'($urandom_range(1, span)));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchecks);
        $finish;
    end

endmodule
